// File: rtl/axi4_lite_mem_responder_pkg.sv
// axi4_lite_mem_responder_pkg: bus widths, memory depth, response codes and FSM state encodings
package axi4_lite_mem_responder_pkg;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 4096;
    localparam int STRB_W    = DATA_W / 8;
    localparam int IDX_W     = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // Full-width compare so addresses at or above the depth never alias onto low words
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(MEM_DEPTH);
    endfunction
endpackage

// File: rtl/axi4_lite_mem_responder_if.sv
// axi4_lite_mem_responder_if: AXI4-Lite channel bundle
//   master: drives AW/W/AR payload+valid, BREADY, RREADY
//   slave:  drives AWREADY, WREADY, ARREADY, B and R channel payload+valid
interface axi4_lite_mem_responder_if;
    import axi4_lite_mem_responder_pkg::*;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi4_lite_mem_responder_bank.sv
// axi4_lite_mem_responder_bank: word memory with one byte-strobed write port and one combinational read port
//   clk_i: clock; we_i/waddr_i/wdata_i/wstrb_i: write port; raddr_i/rdata_o: read port
module axi4_lite_mem_responder_bank
    import axi4_lite_mem_responder_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = mem_q[waddr_i];
        for (int i = 0; i < STRB_W; i++)
            if (wstrb_i[i]) merged[i*8 +: 8] = wdata_i[i*8 +: 8];
    end

    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= merged;

    // A read on the same edge as a write to the same word sees the strobe-merged new word
    assign rdata_o = (we_i && waddr_i == raddr_i) ? merged : mem_q[raddr_i];
endmodule

// File: rtl/axi4_lite_mem_responder.sv
// axi4_lite_mem_responder: AXI4-Lite responder over on-chip word memory with decode-error responses
//   ACLK: clock; ARESETN: synchronous active-low reset; bus: AXI4-Lite slave modport
module axi4_lite_mem_responder
    import axi4_lite_mem_responder_pkg::*;
(
    input  logic ACLK,
    input  logic ARESETN,
    axi4_lite_mem_responder_if.slave bus
);
    logic              rdy_q;
    logic [1:0]        w_state_q, w_state_d;
    logic [0:0]        r_state_q, r_state_d;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [DATA_W-1:0] rdata_q, bank_rdata;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [STRB_W-1:0] c_strb;

    // rdy_q holds all readies low until the first edge out of reset
    assign bus.AWREADY = rdy_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
    assign bus.WREADY  = rdy_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
    assign bus.ARREADY = rdy_q && r_state_q == R_IDLE;
    assign bus.BVALID  = w_state_q == W_RESP;
    assign bus.BRESP   = bresp_q;
    assign bus.RVALID  = r_state_q == R_RESP;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID && bus.WREADY;
    assign ar_hs = bus.ARVALID && bus.ARREADY;

    // Whichever half arrived earlier comes from its latch, the other from the bus
    assign c_addr = w_state_q == W_HAVE_ADDR ? aw_addr_q : bus.AWADDR;
    assign c_data = w_state_q == W_HAVE_DATA ? w_data_q : bus.WDATA;
    assign c_strb = w_state_q == W_HAVE_DATA ? w_strb_q : bus.WSTRB;

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:      w_state_d = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : W_IDLE;
            W_HAVE_ADDR: w_state_d = w_hs ? W_RESP : W_HAVE_ADDR;
            W_HAVE_DATA: w_state_d = aw_hs ? W_RESP : W_HAVE_DATA;
            default:     w_state_d = bus.BREADY ? W_IDLE : W_RESP;
        endcase
    end

    assign commit    = w_state_q != W_RESP && w_state_d == W_RESP;
    assign r_state_d = r_state_q == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (bus.RREADY ? R_IDLE : R_RESP);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rdy_q     <= 1'b0;
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            rdy_q     <= 1'b1;
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            if (commit) bresp_q <= in_range(c_addr) ? OKAY : SLVERR;
            if (ar_hs) begin
                rdata_q <= in_range(bus.ARADDR) ? bank_rdata : '0;
                rresp_q <= in_range(bus.ARADDR) ? OKAY : SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_addr_q <= bus.AWADDR;
        if (w_hs) begin
            w_data_q <= bus.WDATA;
            w_strb_q <= bus.WSTRB;
        end
    end

    // Reset gates the write so a handshake on a reset edge never reaches memory
    axi4_lite_mem_responder_bank u_bank (
        .clk_i   (ACLK),
        .we_i    (commit && ARESETN && in_range(c_addr)),
        .waddr_i (c_addr[IDX_W-1:0]),
        .wdata_i (c_data),
        .wstrb_i (c_strb),
        .raddr_i (bus.ARADDR[IDX_W-1:0]),
        .rdata_o (bank_rdata)
    );
endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// tb_axi4_lite_mem_responder: directed plus randomized checks against a word-array reference model
module tb_axi4_lite_mem_responder;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] model [int];

    axi4_lite_mem_responder_if bus ();

    axi4_lite_mem_responder dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus.slave)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expired(input string tag);
        checks++;
        failures++;
        $display("FAIL %s observed=no_handshake expected=handshake_within_40_cycles", tag);
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] old;
        if (a < 32'd4096) begin
            old = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
            model[int'(a)] = (old & ~strb_mask(s)) | (d & strb_mask(s));
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_awready"}, 32'(bus.AWREADY), 0);
        chk({tag, "_wready"},  32'(bus.WREADY), 0);
        chk({tag, "_arready"}, 32'(bus.ARREADY), 0);
        chk({tag, "_bvalid"},  32'(bus.BVALID), 0);
        chk({tag, "_rvalid"},  32'(bus.RVALID), 0);
        chk({tag, "_bresp"},   32'(bus.BRESP), 0);
        chk({tag, "_rresp"},   32'(bus.RRESP), 0);
        chk({tag, "_rdata"},   bus.RDATA, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int da, input int dw, input int bd, input string tag);
        int c;
        bit ad, wd, ag, wg;
        logic [31:0] er;
        ad = 0; wd = 0; c = 0;
        while (!(ad && wd) && c < 40) begin
            bus.AWVALID = !ad && c >= da;
            bus.AWADDR  = a;
            bus.WVALID  = !wd && c >= dw;
            bus.WDATA   = d;
            bus.WSTRB   = s;
            @(negedge ACLK);
            ag = bus.AWVALID && bus.AWREADY;
            wg = bus.WVALID && bus.WREADY;
            tick();
            ad |= ag;
            wd |= wg;
            c++;
        end
        bus.AWVALID = 0;
        bus.WVALID  = 0;
        if (!(ad && wd)) begin
            expired(tag);
            return;
        end
        er = a < 32'd4096 ? 32'd0 : 32'd2;
        ref_write(a, d, s);
        chk({tag, "_bvalid"}, 32'(bus.BVALID), 1);
        chk({tag, "_bresp"}, 32'(bus.BRESP), er);
        for (int i = 0; i < bd; i++) begin
            tick();
            chk({tag, "_bvalid_hold"}, 32'(bus.BVALID), 1);
            chk({tag, "_bresp_hold"}, 32'(bus.BRESP), er);
            chk({tag, "_awready_hold"}, 32'(bus.AWREADY), 0);
        end
        bus.BREADY = 1;
        tick();
        bus.BREADY = 0;
        chk({tag, "_bvalid_done"}, 32'(bus.BVALID), 0);
        chk({tag, "_awready_back"}, 32'(bus.AWREADY), 1);
        chk({tag, "_wready_back"}, 32'(bus.WREADY), 1);
    endtask

    task automatic rd(input logic [31:0] a, input int dl, input int rdl, input string tag);
        int c;
        bit done, go;
        logic [31:0] ed, er;
        done = 0; c = 0;
        while (!done && c < 40) begin
            bus.ARVALID = c >= dl;
            bus.ARADDR  = a;
            @(negedge ACLK);
            go = bus.ARVALID && bus.ARREADY;
            tick();
            done = go;
            c++;
        end
        bus.ARVALID = 0;
        if (!done) begin
            expired(tag);
            return;
        end
        er = a < 32'd4096 ? 32'd0 : 32'd2;
        ed = a < 32'd4096 ? model[int'(a)] : 32'h0;
        chk({tag, "_rvalid"}, 32'(bus.RVALID), 1);
        chk({tag, "_rresp"}, 32'(bus.RRESP), er);
        chk({tag, "_rdata"}, bus.RDATA, ed);
        for (int i = 0; i < rdl; i++) begin
            tick();
            chk({tag, "_rvalid_hold"}, 32'(bus.RVALID), 1);
            chk({tag, "_rdata_hold"}, bus.RDATA, ed);
            chk({tag, "_arready_hold"}, 32'(bus.ARREADY), 0);
        end
        bus.RREADY = 1;
        tick();
        bus.RREADY = 0;
        chk({tag, "_rvalid_done"}, 32'(bus.RVALID), 0);
        chk({tag, "_arready_back"}, 32'(bus.ARREADY), 1);
    endtask

    task automatic coll(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        logic [31:0] ed;
        bus.AWVALID = 1; bus.AWADDR = a;
        bus.WVALID  = 1; bus.WDATA  = d; bus.WSTRB = s;
        bus.ARVALID = 1; bus.ARADDR = a;
        @(negedge ACLK);
        chk({tag, "_all_ready"}, {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h7);
        tick();
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        ref_write(a, d, s);
        ed = model[int'(a)];
        chk({tag, "_rvalid"}, 32'(bus.RVALID), 1);
        chk({tag, "_rdata_new"}, bus.RDATA, ed);
        chk({tag, "_bvalid"}, 32'(bus.BVALID), 1);
        chk({tag, "_bresp"}, 32'(bus.BRESP), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_bvalid_hold"}, 32'(bus.BVALID), 1);
            chk({tag, "_bresp_hold"}, 32'(bus.BRESP), 0);
            chk({tag, "_awready_hold"}, 32'(bus.AWREADY), 0);
            chk({tag, "_rdata_hold"}, bus.RDATA, ed);
        end
        bus.BREADY = 1; bus.RREADY = 1;
        tick();
        bus.BREADY = 0; bus.RREADY = 0;
        chk({tag, "_bvalid_done"}, 32'(bus.BVALID), 0);
        chk({tag, "_rvalid_done"}, 32'(bus.RVALID), 0);
    endtask

    initial begin
        logic [31:0] a, d;
        bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
        bus.BREADY = 0; bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 0;
        tick();
        tick();
        check_idle_outputs("reset");
        ARESETN = 1;
        chk("reset_release_awready_low", 32'(bus.AWREADY), 0);
        tick();
        chk("ready_after_release", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h7);

        for (int i = 0; i < 16; i++) wr(32'(i), $urandom, 4'hF, 0, 0, 0, "prefill");
        foreach (model[k]) ;
        wr(32'h111, $urandom, 4'hF, 0, 0, 0, "prefill");
        wr(32'h0AF, $urandom, 4'hF, 0, 0, 0, "prefill");
        wr(32'h002, 32'h2222_0002, 4'hF, 0, 0, 0, "prefill");

        ARESETN = 0;
        tick();
        tick();
        ARESETN = 1;
        tick();
        rd(32'd5, 0, 0, "read5_after_reset");

        wr(32'h111, 32'h00FA88F4, 4'hF, 0, 0, 0, "wr111");
        rd(32'h111, 0, 1, "rd111");

        wr(32'h123, 32'h0000_0DDD, 4'hF, 3, 0, 0, "w_before_aw");
        wr(32'h123, 32'h0000_00FF, 4'h1, 0, 0, 0, "strb1");
        rd(32'h123, 0, 0, "rd123");
        chk("rd123_literal", model[32'h123], 32'h0000_0DFF);
        wr(32'h124, 32'hCAFE_F00D, 4'hF, 0, 2, 1, "aw_before_w");
        rd(32'h124, 1, 0, "rd124");

        wr(32'h0AAAAAAA, 32'h1234_5678, 4'hF, 0, 0, 0, "slverr_big");
        wr(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "slverr_4096");
        wr(32'h0000_1005, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, "slverr_4101");
        rd(32'h0000_1000, 0, 0, "rd_4096");
        rd(32'hFFFF_FFFF, 0, 0, "rd_max");
        rd(32'd0, 0, 0, "rd0_unaliased");
        rd(32'd5, 0, 0, "rd5_unaliased");

        coll(32'h0AF, 32'h0000_0001, 4'hF, "coll_full");
        coll(32'h0AF, $urandom, 4'(($urandom_range(1, 14))), "coll_strb");

        bus.AWVALID = 1; bus.AWADDR = 32'h2;
        tick();
        bus.AWVALID = 0;
        chk("have_addr_ready", {30'd0, bus.AWREADY, bus.WREADY}, 32'h1);
        bus.WVALID = 1; bus.WDATA = 32'hBAD0_BAD0; bus.WSTRB = 4'hF;
        ARESETN = 0;
        tick();
        bus.WVALID = 0;
        check_idle_outputs("midwrite_reset");
        tick();
        ARESETN = 1;
        chk("midwrite_release_awready_low", 32'(bus.AWREADY), 0);
        tick();
        chk("midwrite_bvalid", 32'(bus.BVALID), 0);
        chk("midwrite_awready", 32'(bus.AWREADY), 1);
        rd(32'h2, 0, 0, "midwrite_rd2");

        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, 5) == 0 ? 32'(4096 + $urandom_range(0, 100)) : 32'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                wr(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "rand_wr");
            else
                rd(a, $urandom_range(0, 2), $urandom_range(0, 2), "rand_rd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_lite_mem_responder.md
# axi4_lite_mem_responder

AXI4-Lite subordinate (responder) with word-addressed on-chip memory: the target end of the bus that `axi4_lite_master` initiates on. Adds byte-strobe writes, decode-error responses for out-of-range addresses, independent AW/W acceptance and a defined same-address read/write collision rule. Connects through the `slave_if` modport of `axi4_lite_if`.

## Interface
- Addr_Width, 32, address width (from `axi4_lite_Defs`)
- Data_Width, 32, data width (from `axi4_lite_Defs`)
- Mem_Depth, 4096, number of Data_Width words; addresses are word indices
- ACLK  in  1  clock; all logic on posedge
- ARESETN  in  1  reset; synchronous, active-low
- AWADDR/AWVALID/AWREADY  in/in/out  Addr_Width/1/1  write address channel
- WDATA/WSTRB/WVALID/WREADY  in/in/in/out  Data_Width/Data_Width/8/1/1  write data channel, WSTRB[i] enables byte i
- BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
- ARADDR/ARVALID/ARREADY  in/in/out  Addr_Width/1/1  read address channel
- RDATA/RRESP/RVALID/RREADY  out/out/out/in  Data_Width/2/1/1  read data channel

## Operation
- Reset (ARESETN=0 at a posedge): all outputs 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA); both FSMs to idle; pending transactions discarded; memory contents NOT cleared.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. AW+W same edge -> commit, W_RESP. AW only -> latch addr, W_HAVE_ADDR. W only -> latch data/strobe, W_HAVE_DATA.
  - W_HAVE_ADDR: AWREADY=0, WREADY=1; W handshake -> commit, W_RESP. W_HAVE_DATA symmetric.
  - W_RESP: AWREADY=WREADY=0, BVALID=1, BRESP stable; BREADY sampled high -> W_IDLE.
  - Commit: addr < Mem_Depth -> bytes with WSTRB=1 updated, BRESP=OKAY(2'b00); else memory untouched, BRESP=SLVERR(2'b10).
- Read FSM states: R_IDLE, R_RESP.
  - R_IDLE: ARREADY=1; AR handshake -> capture RDATA, RRESP, R_RESP.
  - R_RESP: ARREADY=0, RVALID=1, RDATA/RRESP stable until RREADY sampled high -> R_IDLE.
  - addr < Mem_Depth -> RDATA=mem[addr], RRESP=OKAY; else RDATA=0, RRESP=SLVERR.
- Read and write FSMs independent; both may be active in the same cycle.
- Collision: AR handshake and write commit on the same edge to the same in-range address -> RDATA returns the post-write word (strobe-merged new data).
- Address comparison uses full Addr_Width; no wrap/aliasing (4096 is out of range, not 0).

## Timing
- Write: last of AW/W handshakes at edge k -> memory updated at edge k, BVALID=1 after edge k. B handshake at edge m -> AWREADY=WREADY=1 after edge m. Minimum 2 cycles per write.
- Read: AR handshake at edge k -> RVALID=1 and RDATA valid after edge k. R handshake at edge m -> ARREADY=1 after edge m. Minimum 2 cycles per read.
- First ARESETN=1 edge after reset -> ready outputs go 1 after that edge.
- BVALID/RVALID never drop without the matching READY, except by reset.
- Reset mid-write (any state): no memory update unless commit edge already passed; BVALID=0 next cycle.

## Structure
- `axi4_lite_Defs` gains: `resp_t` (OKAY=2'b00, SLVERR=2'b10), `Mem_Depth`, strobe width `Data_Width/8`, write/read state enums.
- One sub-module: `axi4_lite_mem_bank` — Mem_Depth x Data_Width array, one byte-strobed write port, one combinational read port, write-through bypass for same-address collision. FSMs and range decode stay in the top module.

## Test plan
- Reset, then AR addr 5 -> RVALID one cycle after handshake, RDATA=mem init value, RRESP=00; all outputs 0 during reset.
- AW 0x111 and W 0x00FA88F4 WSTRB=0xF same cycle, BREADY=1 -> BVALID next cycle, BRESP=00; read 0x111 returns 0x00FA88F4.
- W data 0xDDD presented 3 cycles before AW 0x123 -> single commit on AW edge, BRESP=00; WSTRB=0x1 write 0xFF to 0x123 then read -> 0x0DFF.
- Write AW 0xAAAAAAA / read AR 0x1000 -> BRESP=SLVERR, memory unchanged; RDATA=0, RRESP=SLVERR.
- Same-edge write 0x01 to 0x1111-range-valid 0xAF and AR 0xAF -> RDATA=0x01; BREADY held 0 for 4 cycles -> BVALID/BRESP stable, AWREADY=0 throughout.
- ARESETN=0 while in W_HAVE_ADDR for 0x2 -> no write, read 0x2 after reset returns prior value, BVALID=0.
